// File: rtl/alu_dec_seq.sv
// Registered ALU control decoder with valid/ready handshake and MUL/DIV busy sequencing.
// Optional illegal-funct trap: define ALUDEC_ILLEGAL_TRAP_EN.
module alu_dec_seq #(
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 4,
    parameter int CTRL_W  = 3,
    parameter int MC_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               flush,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               busy,
    output logic               mc_done,
    output logic               illegal
);
    localparam int CNT_W = 4;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [CTRL_W-1:0] r_alu_ctrl;

    logic       w_count_zero;
    logic       w_xfer;
    logic       w_legal;
    logic       w_mc;
    logic [2:0] w_code;

    assign w_count_zero = (r_count == '0);
    assign busy         = (r_state == S_BUSY);
    assign mc_done      = busy && w_count_zero;
    assign in_ready     = !flush && ((r_state == S_IDLE) || w_count_zero);
    assign w_xfer       = in_valid && in_ready;
    assign out_valid    = r_out_valid;
    assign alu_ctrl     = r_alu_ctrl;

    // Legal R-type funct values 0..6 map one-to-one onto the control code.
    assign w_legal = (funct < FUNCT_W'(7));

    always_comb begin
        w_code = 3'b000;
        w_mc   = 1'b0;
        case (alu_op[1:0])
            2'b10:   w_code = 3'b000;
            2'b01:   w_code = 3'b001;
            2'b11:   w_code = 3'b011;
            default: begin
                if (w_legal) begin
                    w_code = funct[2:0];
                    w_mc   = (funct[2:0] == 3'd5) || (funct[2:0] == 3'd6);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= '0;
        end else if (flush) begin
            // alu_ctrl intentionally retained across a flush
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_alu_ctrl  <= CTRL_W'(w_code);
            if (w_mc) begin
                r_state <= S_BUSY;
                r_count <= CNT_W'(MC_LAT - 1);
            end else begin
                r_state <= S_IDLE;
                r_count <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == S_BUSY) begin
                if (w_count_zero) r_state <= S_IDLE;
                else              r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef ALUDEC_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_illegal;

    assign w_illegal = (alu_op[1:0] == 2'b00) && !w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_illegal <= 1'b0;
        else if (flush)  r_illegal <= 1'b0;
        else if (w_xfer) r_illegal <= w_illegal;
        else             r_illegal <= 1'b0;
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dec_seq.sv
// Directed bench for alu_dec_seq: abstract remaining-busy-cycles model plus literal spot checks.
module tb_alu_dec_seq;
    localparam int MC_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [3:0] funct;
    logic       flush;
    logic       out_valid;
    logic [2:0] alu_ctrl;
    logic       busy;
    logic       mc_done;
    logic       illegal;

    int checks = 0;
    int failures = 0;

    alu_dec_seq #(.ALUOP_W(2), .FUNCT_W(4), .CTRL_W(3), .MC_LAT(MC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .flush(flush), .out_valid(out_valid),
        .alu_ctrl(alu_ctrl), .busy(busy), .mc_done(mc_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef ALUDEC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Model: m_left = busy cycles still to be shown (0 when idle).
    int         m_left;
    logic       m_ov;
    logic [2:0] m_ctrl;
    logic       m_ill;
    logic       m_ready;

    assign m_ready = !flush && (m_left <= 1);

    function automatic int model_code(input logic [1:0] op, input logic [3:0] f);
        if (op == 2'b10) return 0;
        if (op == 2'b01) return 1;
        if (op == 2'b11) return 3;
        return (f <= 6) ? int'(f) : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_ov <= 1'b0; m_ctrl <= 3'd0; m_ill <= 1'b0;
        end else if (flush) begin
            m_left <= 0; m_ov <= 1'b0; m_ill <= 1'b0;
        end else if (in_valid && m_ready) begin
            m_ov   <= 1'b1;
            m_ctrl <= 3'(model_code(alu_op, funct));
            m_ill  <= TRAP && (alu_op == 2'b00) && (funct > 6);
            m_left <= (alu_op == 2'b00 && (funct == 5 || funct == 6)) ? MC_LAT : 0;
        end else begin
            m_ov  <= 1'b0;
            m_ill <= 1'b0;
            if (m_left > 0) m_left <= m_left - 1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.in_ready", int'(in_ready), int'(m_ready));
        chk("m.out_valid", int'(out_valid), int'(m_ov));
        chk("m.busy", int'(busy), int'(m_left > 0));
        chk("m.mc_done", int'(mc_done), int'(m_left == 1));
        chk("m.alu_ctrl", int'(alu_ctrl), int'(m_ctrl));
        chk("m.illegal", int'(illegal), int'(m_ill));
    end

    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] f, input logic fl);
        @(posedge clk);
        #1;
        in_valid = v; alu_op = op; funct = f; flush = fl;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 4'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'b00; funct = 4'd0; flush = 1'b0;
        #3;
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.alu_ctrl", int'(alu_ctrl), 0);
        @(negedge clk); #1 rst_n = 1'b1;

        // back-to-back single-cycle ops
        step(1'b1, 2'b10, 4'd0, 1'b0);
        step(1'b1, 2'b01, 4'd0, 1'b0);
        @(negedge clk); chk("b2b.add", int'(alu_ctrl), 0); chk("b2b.add.ov", int'(out_valid), 1);
        step(1'b1, 2'b11, 4'd0, 1'b0);
        @(negedge clk); chk("b2b.sub", int'(alu_ctrl), 1);
        step(1'b1, 2'b00, 4'd4, 1'b0);
        @(negedge clk); chk("b2b.or", int'(alu_ctrl), 3);
        idle();
        @(negedge clk); chk("b2b.slt", int'(alu_ctrl), 4); chk("b2b.slt.ov", int'(out_valid), 1);

        // MUL, then SUB accepted on the final busy cycle
        step(1'b1, 2'b00, 4'd5, 1'b0);
        idle();
        @(negedge clk); chk("mul.ctrl", int'(alu_ctrl), 5); chk("mul.c1.ready", int'(in_ready), 0);
        chk("mul.c1.busy", int'(busy), 1);
        idle();
        @(negedge clk); chk("mul.c2.ov", int'(out_valid), 0); chk("mul.c2.ready", int'(in_ready), 0);
        idle();
        @(negedge clk); chk("mul.c3.ready", int'(in_ready), 0); chk("mul.c3.done", int'(mc_done), 0);
        step(1'b1, 2'b01, 4'd0, 1'b0);
        @(negedge clk); chk("mul.c4.done", int'(mc_done), 1); chk("mul.c4.ready", int'(in_ready), 1);
        chk("mul.c4.busy", int'(busy), 1);
        idle();
        @(negedge clk); chk("mul.sub.ctrl", int'(alu_ctrl), 1); chk("mul.sub.ov", int'(out_valid), 1);
        chk("mul.sub.busy", int'(busy), 0);

        // DIV flushed on its second busy cycle; in_valid during flush ignored
        step(1'b1, 2'b00, 4'd6, 1'b0);
        idle();
        @(negedge clk); chk("div.busy", int'(busy), 1);
        step(1'b1, 2'b00, 4'd2, 1'b1);
        @(negedge clk); chk("flush.ready", int'(in_ready), 0);
        idle();
        @(negedge clk); chk("flush.busy", int'(busy), 0); chk("flush.ov", int'(out_valid), 0);
        chk("flush.done", int'(mc_done), 0); chk("flush.ctrl_kept", int'(alu_ctrl), 6);
        idle();
        @(negedge clk); chk("flush.noacc", int'(out_valid), 0); chk("flush.ctrl2", int'(alu_ctrl), 6);

        // illegal funct decodes to ADD
        step(1'b1, 2'b00, 4'b1001, 1'b0);
        idle();
        @(negedge clk); chk("ill.ctrl", int'(alu_ctrl), 0); chk("ill.flag", int'(illegal), int'(TRAP));
        chk("ill.ov", int'(out_valid), 1);

        // async reset while count==2
        step(1'b1, 2'b00, 4'd5, 1'b0);
        idle();
        idle();
        @(negedge clk); chk("arst.pre.busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.busy", int'(busy), 0); chk("arst.done", int'(mc_done), 0);
        chk("arst.ov", int'(out_valid), 0); chk("arst.ready", int'(in_ready), 1);
        in_valid = 1'b1; alu_op = 2'b01; funct = 4'd0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("arst.rec.ov", int'(out_valid), 1); chk("arst.rec.ctrl", int'(alu_ctrl), 1);

        // sweep every funct with continuous in_valid; model covers stalls
        for (int f = 0; f < 16; f++) step(1'b1, 2'b00, 4'(f), 1'b0);
        repeat (MC_LAT + 2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
